// File: rtl/connect_result_packer.sv
// Packs DATA_W-bit results little-endian into PACK-lane words with keep/last,
// buffered in a first-word-fall-through FIFO drained over valid/ready.
module connect_result_packer #(
  parameter int DATA_W     = 8,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     res_vld,
  input  logic [DATA_W-1:0]        res_data,
  input  logic                     res_last,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [DATA_W*PACK-1:0]   out_data,
  output logic [PACK-1:0]          out_keep,
  output logic                     out_last,
  output logic                     ovf
);

  localparam int WW = DATA_W * PACK;
  localparam int CW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = WW + PACK + 1;

  logic [CW-1:0]   r_cnt;
  logic [WW-1:0]   r_stage_data;
  logic [PACK-1:0] r_stage_keep;
  logic [WW-1:0]   w_word_data;
  logic [PACK-1:0] w_word_keep;
  logic            w_complete;
  logic [EW-1:0]   w_entry;

  logic [EW-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_out_vld;
  logic [EW-1:0]   r_head;
  logic            r_ovf;

  logic            w_pop;
  logic            w_full;
  logic            w_push;
  logic            w_drop;
  logic [AW-1:0]   w_rd_ptr_nxt;
  logic [AW:0]     w_count_nxt;
  logic [EW-1:0]   w_head_nxt;

  // Merge the incoming result into the staging word at the current lane.
  always_comb begin
    w_word_data = r_stage_data;
    w_word_keep = r_stage_keep;
    for (int i = 0; i < PACK; i++) begin
      w_word_data[i*DATA_W +: DATA_W] = (res_vld && (r_cnt == CW'(i))) ?
                                        res_data : r_stage_data[i*DATA_W +: DATA_W];
      w_word_keep[i] = r_stage_keep[i] | (res_vld && (r_cnt == CW'(i)));
    end
    w_complete = res_vld && ((r_cnt == CW'(PACK - 1)) || res_last);
    w_entry    = {w_word_data, w_word_keep, res_last};
  end

  // Lane counter and staging word; cleared whenever a word completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_stage_data <= '0;
      r_stage_keep <= '0;
    end else if (w_complete) begin
      r_cnt        <= '0;
      r_stage_data <= '0;
      r_stage_keep <= '0;
    end else if (res_vld) begin
      r_cnt        <= r_cnt + 1'b1;
      r_stage_data <= w_word_data;
      r_stage_keep <= w_word_keep;
    end else begin
      r_cnt        <= r_cnt;
      r_stage_data <= r_stage_data;
      r_stage_keep <= r_stage_keep;
    end
  end

  // FIFO control: a full FIFO still accepts a push when the head pops on the same edge.
  always_comb begin
    w_pop        = r_out_vld && out_rdy;
    w_full       = (r_count == (AW+1)'(FIFO_DEPTH));
    w_push       = w_complete && (!w_full || w_pop);
    w_drop       = w_complete && w_full && !w_pop;
    w_rd_ptr_nxt = w_pop ? (r_rd_ptr + 1'b1) : r_rd_ptr;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Next head entry: the word written this edge lands at the head only when it becomes the sole entry.
  always_comb begin
    w_head_nxt = '0;
    if (w_count_nxt == '0) begin
      w_head_nxt = '0;
    end else if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
      w_head_nxt = w_entry;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // Pointers, occupancy, registered head and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_out_vld <= 1'b0;
      r_head    <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_wr_ptr  <= w_push ? (r_wr_ptr + 1'b1) : r_wr_ptr;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_count   <= w_count_nxt;
      r_out_vld <= (w_count_nxt != '0);
      r_head    <= w_head_nxt;
      r_ovf     <= r_ovf | w_drop;
    end
  end

  assign out_vld  = r_out_vld;
  assign out_data = r_head[EW-1 -: WW];
  assign out_keep = r_head[PACK:1];
  assign out_last = r_head[0];
  assign ovf      = r_ovf;

endmodule
